// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and types for rf_access_scheduler
// (optional read-after-write bypass selected by RF_ARB_BYPASS_EN)
package rf_pkg;
  localparam int DWIDTH = 32;
  localparam int AWIDTH = 5;
  localparam int NREQ = 4;
  typedef logic [2:0] req_idx_t;
  typedef struct packed {
    logic     vld;
    req_idx_t own;
  } rd_own_t;
endpackage

// File: rtl/rf_access_scheduler_rr_pick.sv
// rr_pick: round-robin picker; first requester at or after i_ptr wins
module rr_pick
  import rf_pkg::*;
#(
  parameter int N = NREQ
) (
  input  logic [N-1:0] i_req,
  input  req_idx_t     i_ptr,
  output logic [N-1:0] o_grant,
  output req_idx_t     o_idx,
  output logic         o_found
);
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    o_found = 1'b0;
    // walk offsets from farthest to nearest so the nearest request wins
    for (int k = N - 1; k >= 0; k--)
      for (int i = 0; i < N; i++)
        if (i_req[i] && i == ((int'(i_ptr) + k) % N)) begin
          o_idx = req_idx_t'(i);
          o_found = 1'b1;
        end
    for (int i = 0; i < N; i++) o_grant[i] = o_found && o_idx == req_idx_t'(i);
  end
endmodule

// File: rtl/rf_access_scheduler.sv
// rf_access_scheduler: shares one RF write port and two read ports among NREQ requesters.
// Define RF_ARB_BYPASS_EN to return same-cycle write data to a colliding read.
module rf_access_scheduler #(
  parameter int DWIDTH = rf_pkg::DWIDTH,
  parameter int AWIDTH = rf_pkg::AWIDTH,
  parameter int NREQ = rf_pkg::NREQ
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [NREQ-1:0]        i_req_write,
  input  logic [NREQ*AWIDTH-1:0] i_req_addr,
  input  logic [NREQ*DWIDTH-1:0] i_req_wdata,
  output logic [NREQ-1:0]        o_req_ready,
  output logic [NREQ-1:0]        o_rsp_valid,
  output logic [NREQ*DWIDTH-1:0] o_rsp_data,
  output logic                   o_rf_we,
  output logic [AWIDTH-1:0]      o_rf_wa,
  output logic [DWIDTH-1:0]      o_rf_datain,
  output logic                   o_rf_re_a,
  output logic [AWIDTH-1:0]      o_rf_ra_a,
  output logic                   o_rf_re_b,
  output logic [AWIDTH-1:0]      o_rf_ra_b,
  input  logic [DWIDTH-1:0]      i_rf_out_a,
  input  logic [DWIDTH-1:0]      i_rf_out_b
);
  import rf_pkg::*;

  logic [NREQ-1:0] w_wr_req, w_rd_req, w_wr_gnt, w_a_gnt, w_b_gnt;
  req_idx_t w_wr_idx, w_a_idx, w_b_idx, r_wr_ptr, r_rd_ptr;
  logic w_wr_fnd, w_a_fnd, w_b_fnd;
  rd_own_t r_a, r_b;
  logic [DWIDTH-1:0] w_a_data, w_b_data;

  // reset also masks requests so every combinational output is 0 while held
  assign w_wr_req = i_req_valid & i_req_write & {NREQ{i_rst_n}};
  assign w_rd_req = i_req_valid & ~i_req_write & {NREQ{i_rst_n}};

  rr_pick #(.N(NREQ)) u_wr (.i_req(w_wr_req), .i_ptr(r_wr_ptr), .o_grant(w_wr_gnt),
                            .o_idx(w_wr_idx), .o_found(w_wr_fnd));
  rr_pick #(.N(NREQ)) u_a (.i_req(w_rd_req), .i_ptr(r_rd_ptr), .o_grant(w_a_gnt),
                           .o_idx(w_a_idx), .o_found(w_a_fnd));
  rr_pick #(.N(NREQ)) u_b (.i_req(w_rd_req & ~w_a_gnt), .i_ptr(r_rd_ptr), .o_grant(w_b_gnt),
                           .o_idx(w_b_idx), .o_found(w_b_fnd));

  assign o_req_ready = w_wr_gnt | w_a_gnt | w_b_gnt;
  assign o_rf_we = w_wr_fnd;
  assign o_rf_re_a = w_a_fnd;
  assign o_rf_re_b = w_b_fnd;

  always_comb begin
    o_rf_wa = '0;
    o_rf_datain = '0;
    o_rf_ra_a = '0;
    o_rf_ra_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_wr_gnt[i]) begin
        o_rf_wa = i_req_addr[i*AWIDTH +: AWIDTH];
        o_rf_datain = i_req_wdata[i*DWIDTH +: DWIDTH];
      end
      if (w_a_gnt[i]) o_rf_ra_a = i_req_addr[i*AWIDTH +: AWIDTH];
      if (w_b_gnt[i]) o_rf_ra_b = i_req_addr[i*AWIDTH +: AWIDTH];
    end
  end

  function automatic req_idx_t inc(req_idx_t p);
    return (p == req_idx_t'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (w_wr_fnd) r_wr_ptr <= inc(w_wr_idx);
      if (w_a_fnd) r_rd_ptr <= inc(w_b_fnd ? w_b_idx : w_a_idx);
      r_a <= {w_a_fnd, w_a_idx};
      r_b <= {w_b_fnd, w_b_idx};
    end

`ifdef RF_ARB_BYPASS_EN
  logic r_a_byp, r_b_byp;
  logic [DWIDTH-1:0] r_byp_data;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_a_byp <= 1'b0;
      r_b_byp <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_a_byp <= o_rf_we && o_rf_re_a && o_rf_wa == o_rf_ra_a;
      r_b_byp <= o_rf_we && o_rf_re_b && o_rf_wa == o_rf_ra_b;
      r_byp_data <= o_rf_datain;
    end

  assign w_a_data = r_a_byp ? r_byp_data : i_rf_out_a;
  assign w_b_data = r_b_byp ? r_byp_data : i_rf_out_b;
`else
  assign w_a_data = i_rf_out_a;
  assign w_b_data = i_rf_out_b;
`endif

  // RF outputs reach a requester only through a valid owner slot
  always_comb begin
    o_rsp_valid = '0;
    o_rsp_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_b.vld && r_b.own == req_idx_t'(i)) begin
        o_rsp_valid[i] = 1'b1;
        o_rsp_data[i*DWIDTH +: DWIDTH] = w_b_data;
      end
      if (r_a.vld && r_a.own == req_idx_t'(i)) begin
        o_rsp_valid[i] = 1'b1;
        o_rsp_data[i*DWIDTH +: DWIDTH] = w_a_data;
      end
    end
  end
endmodule

// File: tb/tb_rf_access_scheduler.sv
// tb_rf_access_scheduler: random + directed requester traffic against a register-file
// model; reads are scored against a shadow memory through per-requester queues.
module tb_rf_access_scheduler;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
  } exp_t;

  logic clk, rst_n;
  logic [N-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rsp_data;
  logic rf_we, rf_re_a, rf_re_b;
  logic [AW-1:0] rf_wa, rf_ra_a, rf_ra_b;
  logic [DW-1:0] rf_datain, rf_out_a, rf_out_b;

  logic pend[N];
  logic wr[N];
  logic [AW-1:0] addr[N];
  logic [DW-1:0] wd[N];
  logic [DW-1:0] rsp_d[N];
  int waitc[N];
  logic [DW-1:0] shadow[32];
  logic [DW-1:0] rf_mem[32];
  bit rf_init;
  exp_t q[N][$];
  int wptr, rptr, ncyc, checks, errors;

  rf_access_scheduler #(.DWIDTH(DW), .AWIDTH(AW), .NREQ(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_req_ready(req_ready),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rf_we(rf_we), .o_rf_wa(rf_wa),
    .o_rf_datain(rf_datain), .o_rf_re_a(rf_re_a), .o_rf_ra_a(rf_ra_a), .o_rf_re_b(rf_re_b),
    .o_rf_ra_b(rf_ra_b), .i_rf_out_a(rf_out_a), .i_rf_out_b(rf_out_b)
  );

  for (genvar g = 0; g < N; g++) begin : g_io
    assign req_valid[g] = pend[g];
    assign req_write[g] = wr[g];
    assign req_addr[g*AW +: AW] = addr[g];
    assign req_wdata[g*DW +: DW] = wd[g];
    assign rsp_d[g] = rsp_data[g*DW +: DW];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file: unread ports return garbage so leaks into RSP_DATA show up
  always @(posedge clk) begin
    if (!rf_init) begin
      foreach (rf_mem[a]) rf_mem[a] <= '0;
      rf_init <= 1'b1;
    end else if (rf_we) rf_mem[rf_wa] <= rf_datain;
    rf_out_a <= rf_re_a ? rf_mem[rf_ra_a] : $urandom;
    rf_out_b <= rf_re_b ? rf_mem[rf_ra_b] : $urandom;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    for (int i = 0; i < N; i++) begin
      if (rsp_valid[i]) begin
        if (q[i].size() == 0) chk($sformatf("rsp_spurious[%0d]", i), 1, 0);
        else begin
          exp_t e;
          e = q[i].pop_front();
          chk($sformatf("rsp_cycle[%0d]", i), ncyc, e.cyc);
          chk($sformatf("rsp_data[%0d]", i), rsp_d[i], e.d);
        end
      end else begin
        chk($sformatf("rsp_zero[%0d]", i), rsp_d[i], 0);
        if (q[i].size() > 0 && q[i][0].cyc <= ncyc) begin
          chk($sformatf("rsp_missing[%0d]", i), 0, 1);
          void'(q[i].pop_front());
        end
      end
    end
  end

  task automatic issue(int i, bit w, int a, logic [DW-1:0] d);
    pend[i] = 1'b1;
    wr[i] = w;
    addr[i] = AW'(a);
    wd[i] = d;
    waitc[i] = 0;
  endtask

  // one cycle: predict grants from the round-robin rules, then account the handshakes
  task automatic step();
    logic [N-1:0] er, rdy;
    int ew, ea, eb, j;
    bit live;
    exp_t e;
    @(negedge clk);
    live = rst_n;
    ew = -1;
    ea = -1;
    eb = -1;
    er = '0;
    if (live)
      for (int k = 0; k < N; k++) begin
        j = (wptr + k) % N;
        if (ew < 0 && pend[j] && wr[j]) ew = j;
        j = (rptr + k) % N;
        if (pend[j] && !wr[j]) begin
          if (ea < 0) ea = j;
          else if (eb < 0) eb = j;
        end
      end
    if (ew >= 0) er[ew] = 1'b1;
    if (ea >= 0) er[ea] = 1'b1;
    if (eb >= 0) er[eb] = 1'b1;
    rdy = req_ready;
    chk("ready", rdy, er);
    chk("wport", {rf_we, rf_wa, rf_datain}, ew >= 0 ? {1'b1, addr[ew], wd[ew]} : 38'd0);
    chk("rport_a", {rf_re_a, rf_ra_a}, ea >= 0 ? {1'b1, addr[ea]} : 6'd0);
    chk("rport_b", {rf_re_b, rf_ra_b}, eb >= 0 ? {1'b1, addr[eb]} : 6'd0);
    for (int i = 0; i < N; i++) if (pend[i] && !rdy[i]) waitc[i] = live ? waitc[i] + 1 : 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (rdy[i] && pend[i] && !wr[i]) begin
        e.cyc = ncyc + 1;
        e.d = shadow[addr[i]];
`ifdef RF_ARB_BYPASS_EN
        for (int w = 0; w < N; w++)
          if (rdy[w] && pend[w] && wr[w] && addr[w] == addr[i]) e.d = wd[w];
`endif
        q[i].push_back(e);
      end
    for (int i = 0; i < N; i++)
      if (rdy[i] && pend[i]) begin
        if (wr[i]) shadow[addr[i]] = wd[i];
        chk($sformatf("fair[%0d]", i), waitc[i] <= (wr[i] ? N - 1 : (N + 1) / 2 - 1), 1);
        pend[i] = 1'b0;
      end
    if (!live) begin
      wptr = 0;
      rptr = 0;
    end else begin
      if (ew >= 0) wptr = (ew + 1) % N;
      if (eb >= 0) rptr = (eb + 1) % N;
      else if (ea >= 0) rptr = (ea + 1) % N;
    end
  endtask

  function automatic bit busy();
    foreach (pend[i]) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (busy() && n < 20) begin
      step();
      n++;
    end
    if (busy()) begin
      chk("drain_timeout", 0, 1);
      foreach (pend[i]) pend[i] = 1'b0;
    end
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    foreach (pend[i]) begin
      pend[i] = 1'b0;
      wr[i] = 1'b0;
      addr[i] = '0;
      wd[i] = '0;
      waitc[i] = 0;
    end
    foreach (shadow[a]) shadow[a] = '0;
    repeat (3) step();
    rst_n = 1'b1;
    // write contention: grants 0,1,2,3 from a fresh pointer
    for (int i = 0; i < N; i++) issue(i, 1, i, 20 + 10 * i);
    drain();
    // three concurrent reads: two on A/B, the third next cycle
    issue(0, 0, 0, 0);
    issue(1, 0, 1, 0);
    issue(3, 0, 2, 0);
    drain();
    // single writer then reader
    issue(1, 1, 1, 30);
    drain();
    issue(2, 0, 1, 0);
    drain();
    // same-edge write and read of one address
    issue(0, 1, 5, 60);
    drain();
    issue(0, 1, 5, 70);
    issue(1, 0, 5, 0);
    drain();
    // one write plus two reads in a single cycle
    issue(2, 1, 9, 123);
    issue(0, 0, 5, 0);
    issue(3, 0, 1, 0);
    drain();
    // reset with a read in flight and another request held
    issue(0, 0, 1, 0);
    step();
    issue(2, 0, 3, 0);
    rst_n = 1'b0;
    foreach (q[i]) q[i].delete();
    repeat (2) step();
    rst_n = 1'b1;
    issue(1, 1, 7, 77);
    drain();
    // random traffic with narrow addresses to force collisions
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1)
          issue(i, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
      step();
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
